// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexer with a one-entry
// registered output stage. The source is picked either by an external select
// (mode=0) or by a round-robin arbiter (mode=1).
//
// Build option: define STREAM_MUX_HOLD_GRANT_EN to let a round-robin winner
// keep the grant for up to BURST_MAX consecutive beats while it stays valid.
// Without it, round-robin re-arbitrates after every accepted beat.
//
// Handshake: a beat moves on channel i in a cycle where in_valid[i] and
// in_ready[i] are both 1, and leaves the output when out_valid and out_ready
// are both 1. Once asserted, valid is expected to stay asserted until taken.
// in_ready never depends on in_valid in fixed mode; in round-robin mode the
// grant is a function of the in_valid vector.
module stream_mux_rr #(
   parameter int WIDTH     = 32,
   parameter int NUM_IN    = 4,
   parameter int SEL_W     = 2,
   parameter int BURST_MAX = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_chan,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int IDX_N = 2 ** SEL_W;
   localparam int CNT_W = $clog2(BURST_MAX + 1);

   // Reject configurations the index arithmetic cannot represent.
   if (NUM_IN < 2 || NUM_IN > 16 || IDX_N < NUM_IN || BURST_MAX < 1 || CNT_W < 1) begin : g_bad_cfg
      $error("stream_mux_rr: illegal parameter combination");
   end

   logic [SEL_W-1:0] ptr;        // last channel granted by round-robin
   logic             can_load;   // output register free or draining this cycle
   logic             grant_en;
   logic [SEL_W-1:0] grant_idx;
   logic             xfer;       // an input beat is accepted this cycle
   logic             rr_found;
   logic [SEL_W-1:0] rr_idx;
   logic             hold_act;   // current round-robin owner keeps the grant
   logic [WIDTH-1:0] sel_data;
   logic [IDX_N-1:0] valid_pad;  // in_valid widened so any SEL_W index is legal

   assign valid_pad = IDX_N'(in_valid);
   assign can_load  = !out_valid || out_ready;

   // Round-robin search: first valid channel after ptr, wrapping at NUM_IN.
   always_comb begin
      logic [SEL_W:0] cand;
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         cand = {1'b0, ptr} + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(NUM_IN)) begin
            cand = cand - (SEL_W+1)'(NUM_IN);
         end
         if (!rr_found && valid_pad[cand[SEL_W-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand[SEL_W-1:0];
         end
      end
   end

`ifdef STREAM_MUX_HOLD_GRANT_EN
   logic [CNT_W-1:0] burst_cnt;  // beats taken so far in the current burst

   assign hold_act = mode && (burst_cnt != '0) && valid_pad[ptr];

   // Burst counter: count owner beats, clear on burst limit, drop or mode=0.
   always_ff @(posedge clk) begin
      if (reset || !mode) begin
         burst_cnt <= '0;
      end else if (xfer) begin
         if (hold_act) begin
            if (burst_cnt == CNT_W'(BURST_MAX - 1)) begin
               burst_cnt <= '0;
            end else begin
               burst_cnt <= burst_cnt + CNT_W'(1);
            end
         end else begin
            burst_cnt <= (BURST_MAX > 1) ? CNT_W'(1) : '0;
         end
      end else if (burst_cnt != '0 && !valid_pad[ptr]) begin
         burst_cnt <= '0;
      end
   end
`else
   assign hold_act = 1'b0;
`endif

   // Grant selection: external select in fixed mode, arbiter otherwise.
   always_comb begin
      grant_en  = 1'b0;
      grant_idx = '0;
      if (!mode) begin
         if ({1'b0, sel} < (SEL_W+1)'(NUM_IN)) begin
            grant_en  = 1'b1;
            grant_idx = sel;
         end
      end else if (hold_act) begin
         grant_en  = 1'b1;
         grant_idx = ptr;
      end else if (rr_found) begin
         grant_en  = 1'b1;
         grant_idx = rr_idx;
      end
   end

   // Ready decode: one-hot on the granted channel when the register can load.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_ready[i] = !reset && can_load && grant_en && (grant_idx == SEL_W'(i));
      end
   end

   assign xfer = !reset && can_load && grant_en && valid_pad[grant_idx];

   // Data mux for the granted channel.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output register: load on transfer, empty on drain, hold under backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_chan  <= grant_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer: advances to the winner of each accepted mode=1 beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= SEL_W'(NUM_IN - 1);
      end else if (xfer && mode) begin
         ptr <= grant_idx;
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and randomized checks of stream_mux_rr against
// a behavioural model that follows the grant/handshake rules directly.
module tb_stream_mux_rr;

   localparam int WIDTH     = 32;
   localparam int NUM_IN    = 4;
   localparam int SEL_W     = 3;
   localparam int BURST_MAX = 4;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    mode = 1'b0;
   logic [SEL_W-1:0]        sel = '0;
   logic [NUM_IN*WIDTH-1:0] in_data = '0;
   logic [NUM_IN-1:0]       in_valid = '0;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_chan;
   logic                    out_valid;
   logic                    out_ready = 1'b0;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // model state
   bit                        m_ov   = 1'b0;
   logic [WIDTH-1:0]          m_data = '0;
   int                        m_chan = 0;
   int                        m_ptr  = NUM_IN - 1;
   int                        m_cnt  = 0;
   logic [SEL_W+WIDTH-1:0]    exp_q[$];

   stream_mux_rr #(
      .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .BURST_MAX(BURST_MAX)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // drive one cycle of inputs at the falling edge, random channel data
   task automatic drive(input logic r, input logic m, input logic [SEL_W-1:0] s,
                        input logic [NUM_IN-1:0] v, input logic ordy);
      @(negedge clk);
      reset     = r;
      mode      = m;
      sel       = s;
      in_valid  = v;
      out_ready = ordy;
      for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = $urandom();
   endtask

   // compare process + model step, once per cycle between edges
   always @(negedge clk) begin
      int  g;
      bit  found;
      bit  held;
      bit  can_load;
      bit  xfer;
      logic [NUM_IN-1:0] exp_ready;
      logic [SEL_W+WIDTH-1:0] item;
      #2;
      g = -1;
      held = 1'b0;
      if (!reset) begin
         if (!mode) begin
            if (int'(sel) < NUM_IN) g = int'(sel);
         end else begin
`ifdef STREAM_MUX_HOLD_GRANT_EN
            if (m_cnt > 0 && in_valid[m_ptr]) begin
               g = m_ptr;
               held = 1'b1;
            end
`endif
            found = 1'b0;
            if (g < 0) begin
               for (int k = 1; k <= NUM_IN; k++) begin
                  int c;
                  c = (m_ptr + k) % NUM_IN;
                  if (!found && in_valid[c]) begin
                     g = c;
                     found = 1'b1;
                  end
               end
            end
         end
      end
      can_load  = !m_ov || out_ready;
      exp_ready = (g >= 0 && can_load) ? NUM_IN'(1 << g) : '0;
      xfer      = (g >= 0) && can_load && in_valid[g];

      if (chk_en) begin
         chk("in_ready", 64'(in_ready), 64'(exp_ready));
         chk("out_valid", 64'(out_valid), 64'(m_ov));
         chk("out_data", 64'(out_data), 64'(m_data));
         chk("out_chan", 64'(out_chan), 64'(m_chan));
         if (!reset && m_ov && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", 64'(1), 64'(0));
            end else begin
               item = exp_q.pop_front();
               chk("sb_beat", 64'({out_chan, out_data}), 64'(item));
            end
         end
      end

      if (reset) begin
         m_ov = 1'b0; m_data = '0; m_chan = 0; m_ptr = NUM_IN - 1; m_cnt = 0;
         exp_q.delete();
      end else begin
         if (!mode) begin
            m_cnt = 0;
         end else if (xfer) begin
            if (held) m_cnt = (m_cnt + 1 == BURST_MAX) ? 0 : m_cnt + 1;
            else      m_cnt = (BURST_MAX > 1) ? 1 : 0;
         end else if (m_cnt > 0 && !in_valid[m_ptr]) begin
            m_cnt = 0;
         end
         if (xfer) begin
            if (mode) m_ptr = g;
            m_ov   = 1'b1;
            m_data = in_data[g*WIDTH +: WIDTH];
            m_chan = g;
            exp_q.push_back({SEL_W'(g), in_data[g*WIDTH +: WIDTH]});
         end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   int rr_seq[6] = '{0, 1, 3, 0, 1, 3};
`ifdef STREAM_MUX_HOLD_GRANT_EN
   int hg_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
   int hg_seq[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif

   initial begin
      logic r_m;
      // reset with every channel requesting
      drive(1'b1, 1'b1, '0, 4'b1111, 1'b1);
      #3 chk("rst_ready0", 64'(in_ready), 64'(0));
      chk_en = 1'b1;
      drive(1'b1, 1'b1, '0, 4'b1111, 1'b1);
      #3 chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_ready1", 64'(in_ready), 64'(0));

      // round-robin over channels 0,1,3
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, '0, 4'b1011, 1'b1);
         #3 chk("rr_grant", 64'(in_ready), 64'(1 << rr_seq[i]));
         if (i > 0) chk("rr_chan", 64'(out_chan), 64'(rr_seq[i-1]));
      end

      // fixed select, then out-of-range select
      drive(1'b0, 1'b0, 3'd2, 4'b1111, 1'b1);
      in_data[2*WIDTH +: WIDTH] = 32'hA5A5_0002;
      #3 chk("fix_ready", 64'(in_ready), 64'(4'b0100));
      drive(1'b0, 1'b0, 3'd5, 4'b1111, 1'b1);
      #3 chk("fix_data", 64'(out_data), 64'(32'hA5A5_0002));
      chk("fix_chan", 64'(out_chan), 64'(2));
      chk("sel5_ready", 64'(in_ready), 64'(0));
      drive(1'b0, 1'b0, 3'd5, 4'b1111, 1'b1);
      #3 chk("sel5_drain", 64'(out_valid), 64'(0));

      // backpressure holding a ch1 beat
      drive(1'b0, 1'b1, '0, 4'b0010, 1'b1);
      in_data[1*WIDTH +: WIDTH] = 32'h1111_1111;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, '0, 4'b1111, 1'b0);
         #3 chk("bp_data", 64'(out_data), 64'(32'h1111_1111));
         chk("bp_chan", 64'(out_chan), 64'(1));
         chk("bp_ready", 64'(in_ready), 64'(0));
      end
      drive(1'b0, 1'b1, '0, 4'b1111, 1'b1);
`ifdef STREAM_MUX_HOLD_GRANT_EN
      #3 chk("bp_release", 64'(in_ready), 64'(4'b0010));
`else
      #3 chk("bp_release", 64'(in_ready), 64'(4'b0100));
`endif
      drive(1'b0, 1'b1, '0, 4'b0000, 1'b1);
      #3 chk("bp_reload", 64'(out_valid), 64'(1));

      // burst sequence with channels 0 and 1 requesting
      drive(1'b1, 1'b1, '0, 4'b0000, 1'b1);
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, '0, 4'b0011, 1'b1);
         #3 chk("hg_grant", 64'(in_ready), 64'(1 << hg_seq[i]));
      end

      // reset while a beat is stalled in the output register
      drive(1'b0, 1'b0, 3'd3, 4'b1000, 1'b1);
      drive(1'b0, 1'b0, 3'd3, 4'b1000, 1'b0);
      #3 chk("mr_held", 64'(out_chan), 64'(3));
      drive(1'b1, 1'b0, 3'd3, 4'b1000, 1'b0);
      #3 chk("mr_ready", 64'(in_ready), 64'(0));
      drive(1'b0, 1'b1, '0, 4'b1111, 1'b1);
      #3 chk("mr_valid", 64'(out_valid), 64'(0));
      chk("mr_first", 64'(in_ready), 64'(4'b0001));

      // randomized traffic; mode changes rarely so bursts can develop
      r_m = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) r_m = ~r_m;
         drive(($urandom_range(0, 99) == 0), r_m, SEL_W'($urandom_range(0, 7)),
               NUM_IN'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end

      @(negedge clk);
      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
